// File: rtl/button_decoder.sv
// button_decoder: conditions four raw colour buttons and one start button
// for the game controller. Each input is polarity-corrected, synchronised
// and debounced. An arbiter then reports at most one colour per press on
// IN/IN_VALID, and nothing at all for an ambiguous multi-press.
// Optional build macro: START_COMBO_EN. When it is defined, holding all four
// colours also raises START_GAME and blocks colour reporting.

// One input lane: a 2-flop synchroniser followed by a debounce counter.
module button_decoder_lane #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw,   // 1 = pressed, still asynchronous
  output logic db     // debounced level, 1 = pressed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          db_nxt;

  // Two-stage synchroniser; resets to "released".
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) sync <= '0;
    else        sync <= {sync[0], raw};

  // db flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    db_nxt  = db;
    cnt_nxt = '0;
    if (sync[1] != db) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) db_nxt  = ~db;
      else                                 cnt_nxt = cnt + CW'(1);
    end
  end

  // Debounce state register.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      db  <= db_nxt;
      cnt <= cnt_nxt;
    end
endmodule

module button_decoder #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BTN,
  input  logic       START_BTN,
  output logic [1:0] IN,
  output logic       IN_VALID,
  output logic       START_GAME
);
  localparam int NUM_LANES = 5;  // lanes 0..3 are colours, lane 4 is start

  typedef enum logic [1:0] {IDLE, PRESS, WAIT_REL} state_t;

  logic [NUM_LANES-1:0] pressed, db;
  logic [3:0]           colour;
  logic                 one_hot;
  logic [1:0]           enc, in_nxt;
  logic                 vld_nxt;
  state_t               state, state_nxt;

  assign pressed = BTN_ACTIVE_LOW ? ~{START_BTN, BTN} : {START_BTN, BTN};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    button_decoder_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .CLK  (CLK),
      .RST_N(RST_N),
      .raw  (pressed[i]),
      .db   (db[i])
    );
  end

  assign colour  = db[3:0];
  assign one_hot = (colour != 4'd0) && ((colour & (colour - 4'd1)) == 4'd0);

`ifdef START_COMBO_EN
  // Both terms come straight from debounce flops; an all-colour hold acts as start.
  assign START_GAME = db[4] | (&colour);
`else
  assign START_GAME = db[4];
`endif

  // Encode the single pressed colour (only meaningful when one_hot).
  always_comb begin
    enc = 2'd0;
    for (int k = 0; k < 4; k++)
      if (colour[k]) enc = 2'(k);
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;

  // Next-state logic: accept a lone press, then block until everything is released.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (one_hot)             state_nxt = PRESS;
                else if (colour != 4'd0) state_nxt = WAIT_REL;
      PRESS:    if (!colour[IN])         state_nxt = (colour != 4'd0) ? WAIT_REL : IDLE;
      WAIT_REL: if (colour == 4'd0)      state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
`ifdef START_COMBO_EN
    if (&colour) state_nxt = WAIT_REL;
`endif
  end

  // Output logic: IN loads only on entry to PRESS and holds afterwards.
  always_comb begin
    in_nxt  = IN;
    vld_nxt = (state_nxt == PRESS);
    if (state == IDLE && state_nxt == PRESS) in_nxt = enc;
  end

  // Registered colour handshake.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      IN       <= 2'd0;
      IN_VALID <= 1'b0;
    end else begin
      IN       <= in_nxt;
      IN_VALID <= vld_nxt;
    end
endmodule

// File: tb/tb_button_decoder.sv
// Bench for button_decoder: directed vector table, hand-written reset sequence,
// then randomized stimulus compared each cycle against a behavioural model.
module tb_button_decoder;
  localparam int D = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] BTN = 4'hF;
  logic       START_BTN = 1'b1;
  logic [1:0] IN;
  logic       IN_VALID;
  logic       START_GAME;

  int nchk = 0;
  int nfail = 0;

  button_decoder #(.DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN(BTN), .START_BTN(START_BTN),
    .IN(IN), .IN_VALID(IN_VALID), .START_GAME(START_GAME)
  );

  always #5 CLK = ~CLK;

  // Model: history of pressed samples, one per clock edge (index 0 = newest).
  logic [4:0] hist [0:D+1];
  logic [4:0] m_db;
  int         m_cur;     // accepted colour, -1 when none
  bit         m_blk;     // waiting for full release
  logic [1:0] m_in;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j <= D + 1; j++) hist[j] = '0;
    m_db  = '0;
    m_cur = -1;
    m_blk = 1'b0;
    m_in  = 2'd0;
  endtask

  task automatic model_step();
    logic [3:0] c;
    int         n;
    bit         diff;
    c = m_db[3:0];
    n = $countones(c);
    // Arbiter sees the debounced levels from before this edge.
    if (m_cur >= 0) begin
      if (!c[m_cur]) begin
        m_cur = -1;
        m_blk = (n != 0);
      end
    end else if (m_blk) begin
      if (n == 0) m_blk = 1'b0;
    end else if (n == 1) begin
      for (int k = 0; k < 4; k++)
        if (c[k]) begin
          m_cur = k;
          m_in  = 2'(k);
        end
    end else if (n > 1) begin
      m_blk = 1'b1;
    end
    // A level changes once the D synchronised samples (2 edges old) all disagree.
    for (int j = D + 1; j >= 1; j--) hist[j] = hist[j-1];
    hist[0] = ~{START_BTN, BTN};
    for (int i = 0; i < 5; i++) begin
      diff = 1'b1;
      for (int j = 2; j <= D + 1; j++)
        if (hist[j][i] == m_db[i]) diff = 1'b0;
      if (diff) m_db[i] = ~m_db[i];
    end
  endtask

  // Drive inputs for one clock; called at a negedge, returns at the next negedge.
  task automatic cyc(input logic [3:0] b, input logic s);
    BTN = b;
    START_BTN = s;
    @(posedge CLK);
    if (RST_N) model_step();
    else       model_reset();
    @(negedge CLK);
  endtask

  typedef struct {
    logic [3:0] btn;
    logic       st;
    int         n;
    logic       vld;
    logic [1:0] in;
    logic       sg;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic [3:0] b, input logic s, input int n,
                      input logic v, input logic [1:0] i, input logic g, input string nm);
    vec_t x;
    x.btn = b; x.st = s; x.n = n; x.vld = v; x.in = i; x.sg = g; x.nm = nm;
    tbl.push_back(x);
  endtask

  initial begin
    logic [3:0] rb;
    logic       rs;
    logic [3:0] tmp;
    model_reset();

    // Table: btn, start, cycles, expected IN_VALID, IN, START_GAME.
    addv(4'hF, 1, 10, 0, 0, 0, "idle");
    addv(4'hB, 1,  6, 0, 0, 0, "single_pre");
    addv(4'hB, 1,  1, 1, 2, 0, "single_rise");
    addv(4'hB, 1, 13, 1, 2, 0, "single_hold");
    addv(4'hF, 1,  6, 1, 2, 0, "single_rel_pre");
    addv(4'hF, 1,  1, 0, 2, 0, "single_fall");
    addv(4'hD, 1,  3, 0, 2, 0, "glitch");
    addv(4'hF, 1, 10, 0, 2, 0, "glitch_after");
    addv(4'hF, 0,  5, 0, 2, 0, "start_pre");
    addv(4'hF, 0,  1, 0, 2, 1, "start_rise");
    addv(4'hF, 0,  4, 0, 2, 1, "start_hold");
    addv(4'hF, 1,  5, 0, 2, 1, "start_rel_pre");
    addv(4'hF, 1,  1, 0, 2, 0, "start_fall");
    addv(4'h9, 1, 12, 0, 2, 0, "simul");
    addv(4'hF, 1,  8, 0, 2, 0, "simul_rel");
    addv(4'hD, 1,  6, 0, 2, 0, "c1_pre");
    addv(4'hD, 1,  1, 1, 1, 0, "c1_rise");
    addv(4'hF, 1, 10, 0, 1, 0, "c1_rel");
    addv(4'hB, 0,  7, 1, 2, 1, "start_and_colour");
    addv(4'hF, 1, 10, 0, 2, 0, "start_and_colour_rel");
    addv(4'hE, 1, 10, 1, 0, 0, "ov0");
    addv(4'h6, 1, 10, 1, 0, 0, "ov03");
    addv(4'h7, 1,  6, 1, 0, 0, "ov_rel0_pre");
    addv(4'h7, 1,  1, 0, 0, 0, "ov_rel0");
    addv(4'h7, 1, 10, 0, 0, 0, "ov3_hold");
    addv(4'hF, 1, 10, 0, 0, 0, "ov_rel");
    addv(4'hE, 1,  7, 1, 0, 0, "after_ov");
    addv(4'hF, 1, 10, 0, 0, 0, "after_ov_rel");

    // Reset state.
    @(negedge CLK);
    repeat (3) cyc(4'hF, 1'b1);
    check("reset_in", IN, 0);
    check("reset_valid", IN_VALID, 0);
    check("reset_start", START_GAME, 0);
    RST_N = 1'b1;

    foreach (tbl[t]) begin
      repeat (tbl[t].n) cyc(tbl[t].btn, tbl[t].st);
      check({tbl[t].nm, "_valid"}, IN_VALID, tbl[t].vld);
      check({tbl[t].nm, "_in"}, IN, tbl[t].in);
      check({tbl[t].nm, "_start"}, START_GAME, tbl[t].sg);
    end

    // Reset mid-press: outputs drop at once, held button re-detected afterwards.
    repeat (10) cyc(4'h7, 1'b1);
    check("rst_pre_valid", IN_VALID, 1);
    check("rst_pre_in", IN, 3);
    #2 RST_N = 1'b0;
    #1;
    check("rst_async_valid", IN_VALID, 0);
    check("rst_async_in", IN, 0);
    model_reset();
    @(negedge CLK);
    repeat (2) cyc(4'h7, 1'b1);
    RST_N = 1'b1;
    repeat (6) cyc(4'h7, 1'b1);
    check("rst_rel_pre_valid", IN_VALID, 0);
    cyc(4'h7, 1'b1);
    check("rst_rel_valid", IN_VALID, 1);
    check("rst_rel_in", IN, 3);
    repeat (10) cyc(4'hF, 1'b1);

    // Randomized segments compared every cycle with the model.
    rb = 4'hF;
    rs = 1'b1;
    for (int s = 0; s < 300; s++) begin
      case ($urandom_range(0, 4))
        0:       rb = 4'hF;
        1, 2:    rb = ~(4'b0001 << $urandom_range(0, 3));
        3: begin tmp = 4'($urandom); rb = tmp; end
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) rs = ~rs;
      if ($urandom_range(0, 39) == 0) begin
        RST_N = 1'b0;
        cyc(rb, rs);
        check("rnd_rst_valid", IN_VALID, 0);
        check("rnd_rst_in", IN, 0);
        RST_N = 1'b1;
      end
      repeat ($urandom_range(1, 9)) begin
        cyc(rb, rs);
        check("rnd_valid", IN_VALID, (m_cur >= 0) ? 1 : 0);
        check("rnd_in", IN, m_in);
        check("rnd_start", START_GAME, m_db[4]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
